// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Inter-stage pipeline register for the five-stage MIPS core (one instance
// per stage boundary: F/D, D/E, E/M, M/W). Besides an opaque payload it
// carries the hazard-tracking fields: destination register, Tnew countdown
// and one Tuse field per source channel, plus a valid bit.
//
// Parameters
//   PAYLOAD_W      width of the opaque control/data payload
//   ADDR_W         destination register address width
//   T_W            width of Tnew and of each Tuse field
//   NUM_SRC        number of source-use channels (rs, rt, ...)
//   TUSE_IDLE      Tuse value meaning "operand not used"
//   RESET_PC       PC value held after reset
//   BUBBLE_PC_MODE PC loaded on flush: 0 = zero, 1 = pc_in
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   enable, flush     stage control (see below)
//   valid_in, pc_in, payload_in, dst_addr_in, tnew_in, tuse_in
//                     incoming instruction fields; tuse_in channel k sits at
//                     bits [k*T_W +: T_W]
//   valid_out, pc_out, payload_out, dst_addr_out, tnew_out, tuse_out
//                     stored fields; tnew_out is the stored Tnew minus one,
//                     saturating at zero
//   stats_clr, stall_cnt, bubble_cnt
//                     statistics, present only when PIPE_STAGE_STATS_EN is
//                     defined
//
// Stage control semantics (sampled together on each rising edge):
//   flush = 1               -> load a bubble, regardless of enable
//   flush = 0, enable = 0   -> hold every stored field (stall)
//   flush = 0, enable = 1   -> capture; valid_in = 0 captures a bubble that
//                              still records pc_in
// A bubble always shows dst_addr_out = 0, tnew_out = 0 and every Tuse at
// TUSE_IDLE, so hazard logic never sees a phantom producer or consumer.
//
// Configuration macro: PIPE_STAGE_STATS_EN (adds the statistics counters).
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int          PAYLOAD_W      = 96,
  parameter int          ADDR_W         = 5,
  parameter int          T_W            = 3,
  parameter int          NUM_SRC        = 2,
  parameter int          TUSE_IDLE      = 4,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          BUBBLE_PC_MODE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic [31:0]            pc_in,
  input  logic [PAYLOAD_W-1:0]   payload_in,
  input  logic [ADDR_W-1:0]      dst_addr_in,
  input  logic [T_W-1:0]         tnew_in,
  input  logic [NUM_SRC*T_W-1:0] tuse_in,
  output logic                   valid_out,
  output logic [31:0]            pc_out,
  output logic [PAYLOAD_W-1:0]   payload_out,
  output logic [ADDR_W-1:0]      dst_addr_out,
  output logic [T_W-1:0]         tnew_out,
  output logic [NUM_SRC*T_W-1:0] tuse_out
`ifdef PIPE_STAGE_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            bubble_cnt
`endif
);

  localparam int                TUSE_W        = NUM_SRC * T_W;
  localparam logic [T_W-1:0]    TUSE_IDLE_T   = T_W'(TUSE_IDLE);
  localparam logic [TUSE_W-1:0] TUSE_IDLE_VEC = {NUM_SRC{TUSE_IDLE_T}};

  // -------------------------------------------------------------------------
  // Stored state
  // -------------------------------------------------------------------------
  logic                 valid_q;
  logic [31:0]          pc_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [ADDR_W-1:0]    dst_addr_q;
  logic [T_W-1:0]       tnew_q;
  logic [TUSE_W-1:0]    tuse_q;

  // -------------------------------------------------------------------------
  // Next-state selection
  // -------------------------------------------------------------------------
  logic                 load;
  logic                 bubble;
  logic                 valid_d;
  logic [31:0]          pc_d;
  logic [PAYLOAD_W-1:0] payload_d;
  logic [ADDR_W-1:0]    dst_addr_d;
  logic [T_W-1:0]       tnew_d;
  logic [TUSE_W-1:0]    tuse_d;

  always_comb begin
    // A flush loads even while the stage is stalled.
    load    = flush | enable;
    // Both a flush and an invalid capture produce the bubble field pattern.
    bubble  = flush | ~valid_in;
    valid_d = ~bubble;

    // Only a flush may zero the PC; an invalid capture keeps pc_in so the
    // bubble still records where it came from.
    if (flush && (BUBBLE_PC_MODE == 0)) begin
      pc_d = '0;
    end else begin
      pc_d = pc_in;
    end

    if (bubble) begin
      payload_d  = '0;
      dst_addr_d = '0;
      tnew_d     = '0;
      tuse_d     = TUSE_IDLE_VEC;
    end else begin
      payload_d  = payload_in;
      dst_addr_d = dst_addr_in;
      tnew_d     = tnew_in;
      tuse_d     = tuse_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      payload_q  <= '0;
      dst_addr_q <= '0;
      tnew_q     <= '0;
      tuse_q     <= TUSE_IDLE_VEC;
    end else if (load) begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      payload_q  <= payload_d;
      dst_addr_q <= dst_addr_d;
      tnew_q     <= tnew_d;
      tuse_q     <= tuse_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all driven from registers only
  // -------------------------------------------------------------------------
  assign valid_out    = valid_q;
  assign pc_out       = pc_q;
  assign payload_out  = payload_q;
  assign dst_addr_out = dst_addr_q;
  assign tuse_out     = tuse_q;

  // Tnew is stored relative to the upstream stage; one stage later the
  // result is one cycle closer. Saturate so a ready result stays at zero.
  assign tnew_out = (tnew_q == '0) ? '0 : (tnew_q - T_W'(1));

`ifdef PIPE_STAGE_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
  logic        stall_evt;
  logic        bubble_evt;
  logic [31:0] stall_q;
  logic [31:0] bubble_q;

  // A stall only counts while a real instruction is being held.
  assign stall_evt  = ~flush & ~enable & valid_q;
  assign bubble_evt = flush | (enable & ~valid_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else if (stats_clr) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (bubble_evt && (bubble_q != '1)) begin
        bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Two instances share all inputs: dut0 zeroes the PC on flush, dut1 keeps
// pc_in. The reference model treats the stage as an instruction slot that
// either holds a real instruction or a bubble, and derives the visible
// outputs from that slot.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          PAYLOAD_W = 96;
  localparam int          ADDR_W    = 5;
  localparam int          T_W       = 3;
  localparam int          NUM_SRC   = 2;
  localparam int          TUSE_W    = NUM_SRC * T_W;
  localparam int          TUSE_IDLE = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  // -------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // -------------------------------------------------------------------------
  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 flush;
  logic                 valid_in;
  logic [31:0]          pc_in;
  logic [PAYLOAD_W-1:0] payload_in;
  logic [ADDR_W-1:0]    dst_addr_in;
  logic [T_W-1:0]       tnew_in;
  logic [TUSE_W-1:0]    tuse_in;
  logic                 stats_clr;

  logic                 valid_m0, valid_m1;
  logic [31:0]          pc_m0, pc_m1;
  logic [PAYLOAD_W-1:0] payload_m0, payload_m1;
  logic [ADDR_W-1:0]    dst_m0, dst_m1;
  logic [T_W-1:0]       tnew_m0, tnew_m1;
  logic [TUSE_W-1:0]    tuse_m0, tuse_m1;
  logic [31:0]          stall_m0, stall_m1, bubble_m0, bubble_m1;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .PAYLOAD_W(PAYLOAD_W), .ADDR_W(ADDR_W), .T_W(T_W), .NUM_SRC(NUM_SRC),
    .TUSE_IDLE(TUSE_IDLE), .RESET_PC(RESET_PC), .BUBBLE_PC_MODE(0)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .valid_in(valid_in), .pc_in(pc_in), .payload_in(payload_in),
    .dst_addr_in(dst_addr_in), .tnew_in(tnew_in), .tuse_in(tuse_in),
    .valid_out(valid_m0), .pc_out(pc_m0), .payload_out(payload_m0),
    .dst_addr_out(dst_m0), .tnew_out(tnew_m0), .tuse_out(tuse_m0)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stats_clr(stats_clr), .stall_cnt(stall_m0), .bubble_cnt(bubble_m0)
`endif
  );

  pipe_stage_reg #(
    .PAYLOAD_W(PAYLOAD_W), .ADDR_W(ADDR_W), .T_W(T_W), .NUM_SRC(NUM_SRC),
    .TUSE_IDLE(TUSE_IDLE), .RESET_PC(RESET_PC), .BUBBLE_PC_MODE(1)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .valid_in(valid_in), .pc_in(pc_in), .payload_in(payload_in),
    .dst_addr_in(dst_addr_in), .tnew_in(tnew_in), .tuse_in(tuse_in),
    .valid_out(valid_m1), .pc_out(pc_m1), .payload_out(payload_m1),
    .dst_addr_out(dst_m1), .tnew_out(tnew_m1), .tuse_out(tuse_m1)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stats_clr(stats_clr), .stall_cnt(stall_m1), .bubble_cnt(bubble_m1)
`endif
  );

`ifndef PIPE_STAGE_STATS_EN
  assign stall_m0  = '0;
  assign stall_m1  = '0;
  assign bubble_m0 = '0;
  assign bubble_m1 = '0;
`endif

  // -------------------------------------------------------------------------
  // Reference model: one instruction slot
  // -------------------------------------------------------------------------
  bit                   m_valid;    // slot holds a real instruction
  bit                   m_flushed;  // slot content came from a flush
  logic [31:0]          m_pc;       // PC presented when the slot was filled
  logic [PAYLOAD_W-1:0] m_payload;
  int                   m_dst;
  int                   m_tnew;
  int                   m_tuse[NUM_SRC];
  logic [31:0]          m_stall;
  logic [31:0]          m_bubble;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc0;
    logic [31:0]          pc1;
    logic [PAYLOAD_W-1:0] payload;
    logic [ADDR_W-1:0]    dst;
    logic [T_W-1:0]       tnew;
    logic [TUSE_W-1:0]    tuse;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  function automatic void model_reset();
    m_valid   = 0;
    m_flushed = 0;
    m_pc      = RESET_PC;
    m_stall   = '0;
    m_bubble  = '0;
  endfunction

  // Apply one clock edge with the inputs currently driven.
  function automatic void model_edge();
    if (stats_clr) begin
      m_stall  = '0;
      m_bubble = '0;
    end else begin
      if (!flush && !enable && m_valid && m_stall != ALL_ONES) m_stall = m_stall + 1;
      if ((flush || (enable && !valid_in)) && m_bubble != ALL_ONES) m_bubble = m_bubble + 1;
    end
    if (flush) begin
      m_valid   = 0;
      m_flushed = 1;
      m_pc      = pc_in;
    end else if (enable) begin
      m_valid   = valid_in;
      m_flushed = 0;
      m_pc      = pc_in;
      m_payload = payload_in;
      m_dst     = int'(dst_addr_in);
      m_tnew    = int'(tnew_in);
      for (int k = 0; k < NUM_SRC; k++) m_tuse[k] = int'(tuse_in[k*T_W +: T_W]);
    end
  endfunction

  // What the outside world should see for the current slot content.
  function automatic exp_t model_view();
    exp_t e;
    int   t;
    e.valid = m_valid;
    e.pc0   = m_flushed ? 32'h0 : m_pc;
    e.pc1   = m_pc;
    if (m_valid) begin
      t = (m_tnew > 0) ? m_tnew - 1 : 0;
      e.payload = m_payload;
      e.dst     = ADDR_W'(m_dst);
      e.tnew    = T_W'(t);
      for (int k = 0; k < NUM_SRC; k++) e.tuse[k*T_W +: T_W] = T_W'(m_tuse[k]);
    end else begin
      e.payload = '0;
      e.dst     = '0;
      e.tnew    = '0;
      for (int k = 0; k < NUM_SRC; k++) e.tuse[k*T_W +: T_W] = T_W'(TUSE_IDLE);
    end
    return e;
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    e = exp_t'(exp_q.pop_front());
    check("valid", 160'(valid_m0), 160'(e.valid));
    check("pc_mode0", 160'(pc_m0), 160'(e.pc0));
    check("pc_mode1", 160'(pc_m1), 160'(e.pc1));
    check("payload", 160'(payload_m0), 160'(e.payload));
    check("dst_addr", 160'(dst_m0), 160'(e.dst));
    check("tnew_out", 160'(tnew_m0), 160'(e.tnew));
    check("tuse_out", 160'(tuse_m0), 160'(e.tuse));
    check("mode1_fields", 160'({valid_m1, payload_m1, dst_m1, tnew_m1, tuse_m1}),
          160'({e.valid, e.payload, e.dst, e.tnew, e.tuse}));
`ifdef PIPE_STAGE_STATS_EN
    check("stall_cnt", 160'({stall_m0, stall_m1}), 160'({m_stall, m_stall}));
    check("bubble_cnt", 160'({bubble_m0, bubble_m1}), 160'({m_bubble, m_bubble}));
`endif
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic drive(input logic en, input logic fl, input logic vin, input logic [31:0] pc,
                       input logic [ADDR_W-1:0] dst, input logic [T_W-1:0] tn,
                       input logic [TUSE_W-1:0] tu);
    enable      = en;
    flush       = fl;
    valid_in    = vin;
    pc_in       = pc;
    dst_addr_in = dst;
    tnew_in     = tn;
    tuse_in     = tu;
    payload_in  = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic step();
    model_edge();
    exp_q.push_back(W'(model_view()));
    @(posedge clk);
    #1;
    compare_head();
    stats_clr = 1'b0;
  endtask

  task automatic drive_random();
    logic [TUSE_W-1:0] tu;
    for (int k = 0; k < NUM_SRC; k++) tu[k*T_W +: T_W] = T_W'($urandom_range(0, TUSE_IDLE));
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
          $urandom(), ADDR_W'($urandom_range(0, 31)), T_W'($urandom_range(0, 7)), tu);
    stats_clr = ($urandom_range(0, 31) == 0);
  endtask

  // -------------------------------------------------------------------------
  // Directed and random sequence
  // -------------------------------------------------------------------------
  localparam logic [TUSE_W-1:0] IDLE_VEC = {3'd4, 3'd4};

  initial begin
    reset     = 1'b1;
    stats_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, '0, '0, '0);
    model_reset();

    // Reset before any clock edge.
    #2;
    check("rst_valid", 160'(valid_m0), 160'(0));
    check("rst_pc", 160'({pc_m0, pc_m1}), 160'({RESET_PC, RESET_PC}));
    check("rst_tnew", 160'(tnew_m0), 160'(0));
    check("rst_tuse", 160'(tuse_m0), 160'(IDLE_VEC));
    check("rst_dst", 160'(dst_m0), 160'(0));
    #1 reset = 1'b0;

    // Capture of a valid instruction.
    drive(1'b1, 1'b0, 1'b1, 32'h3004, 5'd8, 3'd2, {3'd1, 3'd0});
    step();
    check("cap_pc", 160'(pc_m0), 160'(32'h3004));
    check("cap_dst", 160'(dst_m0), 160'(8));
    check("cap_tnew", 160'(tnew_m0), 160'(1));
    check("cap_tuse", 160'(tuse_m0), 160'({3'd1, 3'd0}));

    // Hold three cycles with unrelated inputs present.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'hDEAD_0000 + i, 5'd30, 3'd6, {3'd3, 3'd2});
      step();
      check("hold_pc", 160'(pc_m0), 160'(32'h3004));
      check("hold_tnew", 160'(tnew_m0), 160'(1));
      check("hold_dst", 160'(dst_m0), 160'(8));
    end

    // tnew_in = 0 saturates at zero.
    drive(1'b1, 1'b0, 1'b1, 32'h3008, 5'd9, 3'd0, {3'd2, 3'd2});
    step();
    check("sat_tnew", 160'(tnew_m0), 160'(0));
    check("sat_pc", 160'(pc_m0), 160'(32'h3008));

    // Flush wins over a stall.
    drive(1'b0, 1'b1, 1'b1, 32'h3010, 5'd7, 3'd3, {3'd1, 3'd1});
    step();
    check("fl_valid", 160'({valid_m0, valid_m1}), 160'(0));
    check("fl_dst", 160'({dst_m0, dst_m1}), 160'(0));
    check("fl_tuse", 160'({tuse_m0, tuse_m1}), 160'({IDLE_VEC, IDLE_VEC}));
    check("fl_pc_mode1", 160'(pc_m1), 160'(32'h3010));
    check("fl_pc_mode0", 160'(pc_m0), 160'(0));

    // Invalid capture.
    drive(1'b1, 1'b0, 1'b0, 32'h3014, 5'd31, 3'd3, {3'd0, 3'd1});
    step();
    check("inv_dst", 160'(dst_m0), 160'(0));
    check("inv_tnew", 160'(tnew_m0), 160'(0));
    check("inv_pc", 160'({pc_m0, pc_m1}), 160'({32'h3014, 32'h3014}));
    check("inv_tuse", 160'(tuse_m0), 160'(IDLE_VEC));

`ifdef PIPE_STAGE_STATS_EN
    // Clear while capturing a valid instruction, 5 stalls, then 2 flushes.
    drive(1'b1, 1'b0, 1'b1, 32'h3018, 5'd4, 3'd1, {3'd0, 3'd0});
    stats_clr = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, '0, '0, '0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h301C, 5'd4, 3'd1, {3'd0, 3'd0});
      step();
    end
    check("stat_stall5", 160'(stall_m0), 160'(5));
    check("stat_bubble2", 160'(bubble_m0), 160'(2));

    // Clear together with a hold.
    drive(1'b0, 1'b0, 1'b0, 32'h0, '0, '0, '0);
    stats_clr = 1'b1;
    step();
    check("stat_clr", 160'({stall_m0, bubble_m0}), 160'(0));

    // Saturation at all-ones.
    drive(1'b1, 1'b0, 1'b1, 32'h3020, 5'd2, 3'd2, {3'd1, 3'd1});
    step();
    #1;
    force dut0.stall_q  = ALL_ONES;
    force dut1.stall_q  = ALL_ONES;
    force dut0.bubble_q = ALL_ONES;
    force dut1.bubble_q = ALL_ONES;
    #1;
    release dut0.stall_q;
    release dut1.stall_q;
    release dut0.bubble_q;
    release dut1.bubble_q;
    m_stall  = ALL_ONES;
    m_bubble = ALL_ONES;
    drive(1'b0, 1'b0, 1'b0, 32'h0, '0, '0, '0);
    step();
    check("stat_sat_stall", 160'(stall_m0), 160'(ALL_ONES));
    drive(1'b0, 1'b1, 1'b0, 32'h0, '0, '0, '0);
    step();
    check("stat_sat_bubble", 160'(bubble_m0), 160'(ALL_ONES));
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end

    // Reset in the middle of operation, away from any clock edge.
    drive(1'b1, 1'b0, 1'b1, 32'h4000, 5'd12, 3'd5, {3'd2, 3'd3});
    step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_valid", 160'({valid_m0, valid_m1}), 160'(0));
    check("mid_rst_pc", 160'({pc_m0, pc_m1}), 160'({RESET_PC, RESET_PC}));
    check("mid_rst_fields", 160'({dst_m0, tnew_m0, tuse_m0}), 160'({5'd0, 3'd0, IDLE_VEC}));
`ifdef PIPE_STAGE_STATS_EN
    check("mid_rst_cnt", 160'({stall_m0, bubble_m0}), 160'(0));
`endif
    #1 reset = 1'b0;

    // First capture after reset release.
    drive(1'b1, 1'b0, 1'b1, 32'h4004, 5'd3, 3'd4, {3'd4, 3'd1});
    step();
    check("post_rst_tnew", 160'(tnew_m0), 160'(3));

    for (int i = 0; i < 100; i++) begin
      drive_random();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
